// File: rtl/nvram_upload.sv
// nvram_upload: streams every high-score NVRAM entry as a tagged byte on a valid/ready upload port (optional NVUP_DIRTY_EN adds a dirty tracker)
module nvram_upload #(
  parameter logic [16:0] BASE  = 17'h16000,
  parameter int          LEN   = 256,
  parameter logic [3:0]  HINIB = 4'h0
) (
  input  logic        cl,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [7:0]  ra,
  input  logic [3:0]  rd,
  output logic [16:0] upad,
  output logic [7:0]  updt,
  output logic        upvld,
  input  logic        uprdy,
  input  logic        cpuwr,
  output logic        dirty
);
  typedef enum logic [2:0] {IDLE, RDA, CAP, VLD, FIN} state_t;
  state_t state, nxt;
  logic [7:0] idx;
  logic accept, hs, last;
  assign accept = (state == IDLE) && start && !abort;
  assign hs     = (state == VLD) && uprdy;
  assign last   = idx == 8'(LEN - 1);
  assign busy   = state != IDLE;
  assign done   = state == FIN;
  assign upvld  = state == VLD;
  assign ra     = idx;
  assign upad   = BASE + {9'd0, idx};
  // state register
  always_ff @(posedge cl or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state: read, capture, hold until handshake; abort overrides everything
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? RDA : IDLE;
      RDA:     nxt = CAP;
      CAP:     nxt = VLD;
      VLD:     nxt = uprdy ? (last ? FIN : RDA) : VLD;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  // entry index and captured byte; index clears whenever we land in IDLE
  always_ff @(posedge cl or negedge rst_n)
    if (!rst_n) begin
      idx  <= 8'd0;
      updt <= 8'd0;
    end else begin
      idx  <= (accept || nxt == IDLE) ? 8'd0 : (hs && !last) ? idx + 8'd1 : idx;
      updt <= (state == CAP) ? {HINIB, rd} : updt;
    end
`ifdef NVUP_DIRTY_EN
  logic wr_seen;
  // wr_seen remembers writes racing an upload so a finished upload cannot hide them
  always_ff @(posedge cl or negedge rst_n)
    if (!rst_n) begin
      wr_seen <= 1'b0;
      dirty   <= 1'b0;
    end else begin
      wr_seen <= accept ? 1'b0 : (busy && cpuwr) ? 1'b1 : wr_seen;
      dirty   <= (state == FIN) ? (wr_seen | cpuwr) : (dirty | cpuwr);
    end
`else
  logic unused_cpuwr;
  assign unused_cpuwr = cpuwr;
  assign dirty = 1'b0;
`endif
endmodule
